// File: rtl/cordic_pkg.sv
// cordic_pkg: shared CORDIC angle table, angle constants, phase encoding and FSM states
package cordic_pkg;
    typedef enum logic [2:0] {IDLE, PRE, ROT, POST, HOLD} state_t;
    localparam logic [31:0] DEG_90 = 32'd5898240;
    localparam logic [31:0] DEG_180 = 32'd11796480;
    localparam logic [31:0] DEG_270 = 32'd17694720;
    localparam logic [31:0] DEG_360 = 32'd23592960;
    localparam logic [31:0] ATAN [24] = '{
        32'd2949120, 32'd1740967, 32'd919879, 32'd466945,
        32'd234379, 32'd117304, 32'd58666, 32'd29335,
        32'd14668, 32'd7334, 32'd3667, 32'd1833,
        32'd917, 32'd458, 32'd229, 32'd115,
        32'd57, 32'd29, 32'd14, 32'd7,
        32'd4, 32'd2, 32'd1, 32'd0
    };
    function automatic logic [31:0] phase_enc(input logic [8:0] deg);
        logic [1:0] q;
        logic [8:0] off;
        q = deg <= 9'd90 ? 2'd0 : deg <= 9'd180 ? 2'd1 : deg <= 9'd270 ? 2'd2 : 2'd3;
        off = deg - 9'(q) * 9'd90;
        return {14'b0, q, 7'b0, off};
    endfunction
endpackage

// File: rtl/cordic_vec_stage.sv
// cordic_vec_stage: one combinational vectoring micro-rotation driving y toward zero
module cordic_vec_stage
    import cordic_pkg::*;
#(
    parameter int W = 34,
    parameter int ZW = 32
) (
    input  logic [W-1:0]  x,
    input  logic [W-1:0]  y,
    input  logic [ZW-1:0] z,
    input  logic [4:0]    i,
    output logic [W-1:0]  x_next,
    output logic [W-1:0]  y_next,
    output logic [ZW-1:0] z_next
);
    logic [W-1:0] xs, ys;
    logic [ZW-1:0] a;
    assign xs = $signed(x) >>> i;
    assign ys = $signed(y) >>> i;
    assign a = ZW'(ATAN[i]);
    assign x_next = y[W-1] ? x - ys : x + ys;
    assign y_next = y[W-1] ? y + xs : y - xs;
    assign z_next = y[W-1] ? z - a : z + a;
endmodule

// File: rtl/cordic_vectoring.sv
// cordic_vectoring: iterative vectoring CORDIC returning encoded phase, degrees and scaled magnitude
module cordic_vectoring
    import cordic_pkg::*;
#(
    parameter int ITER = 16,
    parameter int DW = 32,
    parameter int ZW = 32
) (
    input  logic          CLK_50M,
    input  logic          RST,
    input  logic          In_Valid,
    output logic          In_Ready,
    input  logic [DW-1:0] Cos,
    input  logic [DW-1:0] Sin,
    output logic          Out_Valid,
    input  logic          Out_Ready,
    output logic [31:0]   Phase,
    output logic [8:0]    Phase_Deg,
    output logic [DW-1:0] Mag,
    output logic          Zero
);
    localparam int W = DW + 2;
    state_t state;
    logic signed [W-1:0] x, y;
    logic signed [ZW-1:0] z;
    logic [4:0] i;
    logic zero;
    logic [W-1:0] x_next, y_next;
    logic [ZW-1:0] z_next;
    logic [ZW-1:0] z_pos, z_rnd;
    logic [8:0] deg_raw, deg;

    cordic_vec_stage #(.W(W), .ZW(ZW)) u_stage (
        .x(x), .y(y), .z(z), .i(i),
        .x_next(x_next), .y_next(y_next), .z_next(z_next)
    );

    // fold the accumulated angle into 0..359 whole degrees, rounding to nearest
    always_comb begin
        z_pos = z[ZW-1] ? z + ZW'(DEG_360) : z;
        z_rnd = z_pos + ZW'(32'h8000);
        deg_raw = 9'(z_rnd >> 16);
        deg = deg_raw == 9'd360 ? 9'd0 : deg_raw;
    end

    // handshake, pre-rotation, micro-rotation sequencing and registered results
    always_ff @(posedge CLK_50M) begin
        if (RST) begin
            state <= IDLE;
            In_Ready <= 1'b0;
            Out_Valid <= 1'b0;
            Phase <= '0;
            Phase_Deg <= '0;
            Mag <= '0;
            Zero <= 1'b0;
            x <= '0;
            y <= '0;
            z <= '0;
            i <= '0;
            zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (In_Valid && In_Ready) begin
                        x <= {{2{Cos[DW-1]}}, Cos};
                        y <= {{2{Sin[DW-1]}}, Sin};
                        In_Ready <= 1'b0;
                        state <= PRE;
                    end else begin
                        In_Ready <= 1'b1;
                    end
                end
                PRE: begin
                    x <= x[W-1] ? -x : x;
                    y <= x[W-1] ? -y : y;
                    z <= x[W-1] ? ZW'(DEG_180) : '0;
                    zero <= x == '0 && y == '0;
                    i <= '0;
                    state <= ROT;
                end
                ROT: begin
                    x <= x_next;
                    y <= y_next;
                    z <= z_next;
                    i <= i + 5'd1;
                    state <= i == 5'(ITER - 1) ? POST : ROT;
                end
                POST: begin
                    Phase <= zero ? '0 : phase_enc(deg);
                    Phase_Deg <= zero ? '0 : deg;
                    Mag <= zero ? '0 : x[DW-1:0];
                    Zero <= zero;
                    Out_Valid <= 1'b1;
                    state <= HOLD;
                end
                HOLD: begin
                    if (Out_Ready) begin
                        Out_Valid <= 1'b0;
                        In_Ready <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cordic_vectoring.sv
// tb_cordic_vectoring: directed vectors, closed-loop phase sweep, backpressure and reset checks
module tb_cordic_vectoring;
    logic CLK_50M = 1'b0;
    logic RST, In_Valid, In_Ready, Out_Valid, Out_Ready, Zero;
    logic [31:0] Cos, Sin, Phase, Mag;
    logic [8:0] Phase_Deg;
    int n_tests = 0;
    int n_fail = 0;

    typedef struct {
        int c;
        int s;
        logic [31:0] ph;
        int deg;
        logic z;
        logic chk_mag;
        int mag;
        int tol;
    } vec_t;
    vec_t tv [11];

    cordic_vectoring dut (
        .CLK_50M(CLK_50M), .RST(RST), .In_Valid(In_Valid), .In_Ready(In_Ready),
        .Cos(Cos), .Sin(Sin), .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
        .Phase(Phase), .Phase_Deg(Phase_Deg), .Mag(Mag), .Zero(Zero)
    );

    always #10 CLK_50M = ~CLK_50M;

    function automatic logic [31:0] enc_exp(input int d);
        int q, o;
        if (d <= 90) begin q = 0; o = d; end
        else if (d <= 180) begin q = 1; o = d - 90; end
        else if (d <= 270) begin q = 2; o = d - 180; end
        else begin q = 3; o = d - 270; end
        return 32'((q << 16) | o);
    endfunction

    task automatic check(input string name, input longint got, input longint exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic send(input int c, input int s, output int lat);
        int n = 0;
        while (!In_Ready && n < 50) begin
            @(posedge CLK_50M); #1;
            n++;
        end
        Cos = c;
        Sin = s;
        In_Valid = 1'b1;
        @(posedge CLK_50M); #1;
        In_Valid = 1'b0;
        lat = 0;
        while (!Out_Valid && lat < 100) begin
            @(posedge CLK_50M); #1;
            lat++;
        end
    endtask

    task automatic consume();
        Out_Ready = 1'b1;
        @(posedge CLK_50M); #1;
        Out_Ready = 1'b0;
        check("out_valid_drop", longint'(Out_Valid), 0);
    endtask

    initial begin
        int lat, hi, c, s;
        real r;
        logic [31:0] ph0;
        RST = 1'b1;
        In_Valid = 1'b0;
        Out_Ready = 1'b0;
        Cos = '0;
        Sin = '0;
        tv[0]  = '{65536, 0, 32'h00000000, 0, 1'b0, 1'b1, 107921, 8};
        tv[1]  = '{0, 65536, 32'h0000005A, 90, 1'b0, 1'b0, 0, 0};
        tv[2]  = '{-65536, 0, 32'h0001005A, 180, 1'b0, 1'b0, 0, 0};
        tv[3]  = '{0, -65536, 32'h0002005A, 270, 1'b0, 1'b0, 0, 0};
        tv[4]  = '{65526, -1144, 32'h00030059, 359, 1'b0, 1'b0, 0, 0};
        tv[5]  = '{0, 0, 32'h00000000, 0, 1'b1, 1'b1, 0, 0};
        tv[6]  = '{65536, 65536, 32'h0000002D, 45, 1'b0, 1'b0, 0, 0};
        tv[7]  = '{-65536, 65536, 32'h0001002D, 135, 1'b0, 1'b0, 0, 0};
        tv[8]  = '{-65536, -65536, 32'h0002002D, 225, 1'b0, 1'b0, 0, 0};
        tv[9]  = '{65536, -65536, 32'h0003002D, 315, 1'b0, 1'b0, 0, 0};
        tv[10] = '{-65536, -1144, 32'h00020001, 181, 1'b0, 1'b0, 0, 0};

        @(posedge CLK_50M); #1;
        check("rst_in_ready", longint'(In_Ready), 0);
        check("rst_out_valid", longint'(Out_Valid), 0);
        check("rst_phase", longint'(Phase), 0);
        check("rst_deg", longint'(Phase_Deg), 0);
        check("rst_mag", longint'(Mag), 0);
        check("rst_zero", longint'(Zero), 0);
        RST = 1'b0;
        @(posedge CLK_50M); #1;
        check("rst_in_ready_after", longint'(In_Ready), 1);

        for (int n = 0; n < 11; n++) begin
            send(tv[n].c, tv[n].s, lat);
            check($sformatf("v%0d_latency", n), lat, 18);
            check($sformatf("v%0d_phase", n), longint'(Phase), longint'(tv[n].ph));
            check($sformatf("v%0d_deg", n), longint'(Phase_Deg), tv[n].deg);
            check($sformatf("v%0d_zero", n), longint'(Zero), longint'(tv[n].z));
            check($sformatf("v%0d_in_ready", n), longint'(In_Ready), 0);
            if (tv[n].chk_mag) begin
                n_tests++;
                if ($signed(Mag) > tv[n].mag + tv[n].tol || $signed(Mag) < tv[n].mag - tv[n].tol) begin
                    n_fail++;
                    $display("FAIL v%0d_mag: got %0d expected %0d +/- %0d", n, $signed(Mag), tv[n].mag, tv[n].tol);
                end
            end
            consume();
        end

        for (int k = 0; k < 360; k++) begin
            r = k * 3.14159265358979 / 180.0;
            c = $rtoi($floor(1048576.0 * $cos(r) + 0.5));
            s = $rtoi($floor(1048576.0 * $sin(r) + 0.5));
            send(c, s, lat);
            check($sformatf("loop%0d_phase", k), longint'(Phase), longint'(enc_exp(k)));
            consume();
        end

        send(0, 65536, lat);
        ph0 = Phase;
        check("bp_phase_first", longint'(ph0), 32'h5A);
        for (int k = 0; k < 10; k++) begin
            @(posedge CLK_50M); #1;
            check($sformatf("bp%0d_phase", k), longint'(Phase), longint'(ph0));
            check($sformatf("bp%0d_valid", k), longint'(Out_Valid), 1);
            check($sformatf("bp%0d_in_ready", k), longint'(In_Ready), 0);
        end
        consume();

        Cos = 65536;
        Sin = 0;
        In_Valid = 1'b1;
        @(posedge CLK_50M); #1;
        In_Valid = 1'b0;
        repeat (5) @(posedge CLK_50M);
        #1;
        RST = 1'b1;
        @(posedge CLK_50M); #1;
        RST = 1'b0;
        check("mid_rst_in_ready", longint'(In_Ready), 0);
        check("mid_rst_out_valid", longint'(Out_Valid), 0);
        check("mid_rst_phase", longint'(Phase), 0);
        check("mid_rst_deg", longint'(Phase_Deg), 0);
        check("mid_rst_mag", longint'(Mag), 0);
        check("mid_rst_zero", longint'(Zero), 0);
        @(posedge CLK_50M); #1;
        check("mid_rst_in_ready_after", longint'(In_Ready), 1);
        hi = 0;
        for (int k = 0; k < 25; k++) begin
            @(posedge CLK_50M); #1;
            if (Out_Valid) hi++;
        end
        check("mid_rst_no_stale_valid", hi, 0);

        send(-65536, 0, lat);
        check("post_rst_latency", lat, 18);
        check("post_rst_deg", longint'(Phase_Deg), 180);
        consume();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
